// File: rtl/rice_data_memory_responder.sv
// Load/store responder for the core data interface: one-entry registered response over a word RAM.
// Optional access counters (o_load_count/o_store_count) are enabled by RICE_DATA_MEMORY_ACCESS_COUNTER_EN.
module rice_data_memory_responder #(
  parameter int DEPTH_WORDS   = 1024,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_request_valid,
  output logic                     o_request_ready,
  input  logic [1:0]               i_access_type,
  input  logic [2:0]               i_access_mode,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  input  logic [31:0]              i_write_data,
  output logic                     o_response_valid,
  input  logic                     i_response_ready,
  output logic [31:0]              o_read_data,
`ifdef RICE_DATA_MEMORY_ACCESS_COUNTER_EN
  output logic [31:0]              o_load_count,
  output logic [31:0]              o_store_count,
`endif
  output logic                     o_error
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  localparam logic [1:0] TYPE_STORE = 2'd1;
  localparam logic [1:0] TYPE_LOAD  = 2'd2;

  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_HU = 3'b101;
  localparam logic [2:0] MODE_W  = 3'b010;

  typedef enum logic {ST_IDLE, ST_RESP} state_t;

  state_t      r_state;
  logic [31:0] r_read_data;
  logic        r_error;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic             w_accept;
  logic             w_is_store;
  logic             w_is_load;
  logic             w_mode_ok;
  logic             w_is_half;
  logic             w_is_word;
  logic             w_out_of_range;
  logic             w_error;
  logic             w_store_en;
  logic [IDX_W-1:0] w_index;
  logic [3:0]       w_strobe;
  logic [31:0]      w_lane_data;
  logic [31:0]      w_word;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_load_data;

  assign o_response_valid = (r_state == ST_RESP);
  assign o_request_ready  = !o_response_valid || i_response_ready;
  assign o_read_data      = r_read_data;
  assign o_error          = r_error;

  assign w_accept       = i_request_valid && o_request_ready;
  assign w_is_store     = (i_access_type == TYPE_STORE);
  assign w_is_load      = (i_access_type == TYPE_LOAD);
  assign w_index        = i_address[IDX_W+1:2];
  assign w_out_of_range = |i_address[ADDRESS_WIDTH-1:IDX_W+2];
  assign w_is_half      = (i_access_mode == MODE_H) || (i_access_mode == MODE_HU);
  assign w_is_word      = (i_access_mode == MODE_W);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_mode_ok = 1'b0;
    case (i_access_mode)
      MODE_B, MODE_BU, MODE_H, MODE_HU, MODE_W: w_mode_ok = 1'b1;
      default:                                  w_mode_ok = 1'b0;
    endcase
  end

  assign w_error = !(w_is_store || w_is_load)
                || !w_mode_ok
                || (w_is_store && i_access_mode[2])
                || (w_is_half && i_address[0])
                || (w_is_word && (i_address[1:0] != 2'b00))
                || w_out_of_range;

  assign w_store_en = w_accept && w_is_store && !w_error;

  // Narrow stores replicate the data across lanes so the strobe alone picks the target bytes.
  always_comb begin
    w_strobe    = 4'b0000;
    w_lane_data = i_write_data;
    case (i_access_mode)
      MODE_B: begin
        w_strobe    = 4'b0001 << i_address[1:0];
        w_lane_data = {4{i_write_data[7:0]}};
      end
      MODE_H: begin
        w_strobe    = 4'b0011 << i_address[1:0];
        w_lane_data = {2{i_write_data[15:0]}};
      end
      MODE_W: w_strobe = 4'b1111;
      default: w_strobe = 4'b0000;
    endcase
  end

  // NOTE: the RAM array has no reset branch; resetting it would prevent block-RAM inference and its contents are undefined by design.
  always_ff @(posedge i_clk) begin
    if (w_store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (w_strobe[i]) r_mem[w_index][8*i +: 8] <= w_lane_data[8*i +: 8];
      end
    end
  end

  assign w_word = r_mem[w_index];

  always_comb begin
    w_byte = w_word[7:0];
    case (i_address[1:0])
      2'd0: w_byte = w_word[7:0];
      2'd1: w_byte = w_word[15:8];
      2'd2: w_byte = w_word[23:16];
      2'd3: w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase
  end

  assign w_half = i_address[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_load_data = 32'd0;
    case (i_access_mode)
      MODE_B:  w_load_data = {{24{w_byte[7]}}, w_byte};
      MODE_BU: w_load_data = {24'd0, w_byte};
      MODE_H:  w_load_data = {{16{w_half[15]}}, w_half};
      MODE_HU: w_load_data = {16'd0, w_half};
      MODE_W:  w_load_data = w_word;
      default: w_load_data = 32'd0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_read_data <= 32'd0;
      r_error     <= 1'b0;
`ifdef RICE_DATA_MEMORY_ACCESS_COUNTER_EN
      o_load_count  <= 32'd0;
      o_store_count <= 32'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (!w_accept && i_response_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_accept) begin
        r_error     <= w_error;
        r_read_data <= (w_is_load && !w_error) ? w_load_data : 32'd0;
`ifdef RICE_DATA_MEMORY_ACCESS_COUNTER_EN
        if (w_is_load && !w_error)  o_load_count  <= o_load_count + 32'd1;
        if (w_is_store && !w_error) o_store_count <= o_store_count + 32'd1;
`endif
      end
    end
  end

endmodule
